// File: rtl/memory_arbiter_param.sv
// Tile-burst RAM arbiter: scratchpad row bursts plus I/D cache single beats on one RAM port.
// Optional macro ARB_FAIRNESS_EN lets pending cache requests win over scratchpad after each SP burst.
package caches_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module memory_arbiter_param
    import caches_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ROWS   = 4,
    parameter int WPR    = 2,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sp_load_req,
    input  logic [ADDR_W-1:0]     sp_load_addr,
    output logic [WPR*DATA_W-1:0] sp_load_data,
    output logic [RW-1:0]         sp_load_row,
    output logic                  sp_load_hit,
    input  logic                  sp_store_req,
    input  logic [ADDR_W-1:0]     sp_store_addr,
    input  logic [WPR*DATA_W-1:0] sp_store_data,
    output logic [RW-1:0]         sp_store_row,
    output logic                  sp_store_hit,
    input  logic [ADDR_W-1:0]     sp_stride,
    input  logic                  dREN,
    input  logic                  dWEN,
    input  logic [ADDR_W-1:0]     daddr,
    input  logic [DATA_W-1:0]     dstore,
    output logic                  dwait,
    output logic [DATA_W-1:0]     dload,
    input  logic                  iREN,
    input  logic [ADDR_W-1:0]     iaddr,
    output logic                  iwait,
    output logic [DATA_W-1:0]     iload,
    output logic [ADDR_W-1:0]     ramaddr,
    output logic [DATA_W-1:0]     ramstore,
    output logic                  ramREN,
    output logic                  ramWEN,
    input  logic [DATA_W-1:0]     ramload,
    input  ramstate_t             ramstate
);

    typedef enum logic [2:0] {IDLE, SP_LOAD, SP_STORE, DCACHE, ICACHE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_cnt_q, row_cnt_d;
    logic [WW-1:0]         word_cnt_q, word_cnt_d;
    logic [WPR*DATA_W-1:0] load_data_q, load_data_d;
    logic [RW-1:0]         load_row_q, load_row_d;
    logic                  load_hit_q, load_hit_d;
    logic                  load_armed_q, load_armed_d;
    logic                  store_armed_q, store_armed_d;
    logic                  cache_first;

    logic                  beat_done;
    logic                  last_word;
    logic                  last_row;
    logic                  d_req;
    logic                  load_ok;
    logic                  store_ok;
    logic                  sp_req_live;
    logic [ADDR_W-1:0]     beat_offset;

    assign beat_done   = (ramstate == ACCESS);
    assign last_word   = (word_cnt_q == WW'(WPR - 1));
    assign last_row    = (row_cnt_q == RW'(ROWS - 1));
    assign d_req       = dREN | dWEN;
    assign load_ok     = sp_load_req & load_armed_q;
    assign store_ok    = sp_store_req & store_armed_q;
    assign sp_req_live = (state_q == SP_LOAD) ? sp_load_req : sp_store_req;
    assign beat_offset = (ADDR_W'(row_cnt_q) * ADDR_W'(WPR) + ADDR_W'(word_cnt_q)) * sp_stride;

`ifdef ARB_FAIRNESS_EN
    logic fair_q, fair_d;

    always_comb begin
        fair_d = fair_q;
        if ((state_q == SP_LOAD || state_q == SP_STORE) && state_d == IDLE) begin
            fair_d = 1'b1;
        end
        if (state_q == IDLE && (state_d == DCACHE || state_d == ICACHE)) begin
            fair_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fair_q <= 1'b0;
        end else begin
            fair_q <= fair_d;
        end
    end

    assign cache_first = fair_q;
`else
    assign cache_first = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            word_cnt_q    <= '0;
            load_data_q   <= '0;
            load_row_q    <= '0;
            load_hit_q    <= 1'b0;
            load_armed_q  <= 1'b1;
            store_armed_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            word_cnt_q    <= word_cnt_d;
            load_data_q   <= load_data_d;
            load_row_q    <= load_row_d;
            load_hit_q    <= load_hit_d;
            load_armed_q  <= load_armed_d;
            store_armed_q <= store_armed_d;
        end
    end

    // Grants only ever start from IDLE, so an active burst is never preempted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cache_first && d_req)      state_d = DCACHE;
                else if (cache_first && iREN)  state_d = ICACHE;
                else if (load_ok)              state_d = SP_LOAD;
                else if (store_ok)             state_d = SP_STORE;
                else if (d_req)                state_d = DCACHE;
                else if (iREN)                 state_d = ICACHE;
            end
            SP_LOAD, SP_STORE: begin
                if (!sp_req_live || (beat_done && last_word && last_row)) begin
                    state_d = IDLE;
                end
            end
            DCACHE: begin
                if (!d_req || beat_done) state_d = IDLE;
            end
            ICACHE: begin
                if (!iREN || beat_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A dropped request discards any beat finishing in the same cycle.
    always_comb begin
        row_cnt_d     = row_cnt_q;
        word_cnt_d    = word_cnt_q;
        load_data_d   = load_data_q;
        load_row_d    = load_row_q;
        load_hit_d    = 1'b0;
        load_armed_d  = load_armed_q | ~sp_load_req;
        store_armed_d = store_armed_q | ~sp_store_req;
        case (state_q)
            SP_LOAD, SP_STORE: begin
                if (!sp_req_live) begin
                    row_cnt_d  = '0;
                    word_cnt_d = '0;
                end else if (beat_done) begin
                    if (state_q == SP_LOAD) begin
                        load_data_d[word_cnt_q*DATA_W +: DATA_W] = ramload;
                    end
                    if (last_word) begin
                        word_cnt_d = '0;
                        row_cnt_d  = last_row ? '0 : row_cnt_q + RW'(1);
                        if (state_q == SP_LOAD) begin
                            load_row_d = row_cnt_q;
                            load_hit_d = 1'b1;
                        end
                        if (last_row) begin
                            if (state_q == SP_LOAD) load_armed_d = 1'b0;
                            else                    store_armed_d = 1'b0;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + WW'(1);
                    end
                end
            end
            default: begin
                row_cnt_d  = '0;
                word_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        ramaddr      = '0;
        ramstore     = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        dwait        = 1'b1;
        dload        = '0;
        iwait        = 1'b1;
        iload        = '0;
        sp_store_hit = 1'b0;
        case (state_q)
            SP_LOAD: begin
                ramaddr = sp_load_addr + beat_offset;
                ramREN  = 1'b1;
            end
            SP_STORE: begin
                ramaddr      = sp_store_addr + beat_offset;
                ramWEN       = 1'b1;
                ramstore     = sp_store_data[word_cnt_q*DATA_W +: DATA_W];
                sp_store_hit = sp_store_req & beat_done & last_word;
            end
            DCACHE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                dwait    = ~beat_done;
            end
            ICACHE: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                iload   = ramload;
                iwait   = ~beat_done;
            end
            default: ;
        endcase
    end

    assign sp_load_data = load_data_q;
    assign sp_load_row  = load_row_q;
    assign sp_load_hit  = load_hit_q;
    assign sp_store_row = row_cnt_q;

endmodule
